// File: rtl/obs_split_stream_206bit.sv
// Collects two streamed N-bit GF(2) operands beat by beat and splits each into
// even/odd coefficient halves plus their XOR sum for the OBS sub-multipliers.
module obs_split_stream_206bit #(
  parameter int unsigned N = 206,
  parameter int unsigned W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [N/2-1:0]   a_even,
  output logic [N/2-1:0]   a_odd,
  output logic [N/2-1:0]   a_sum,
  output logic [N/2-1:0]   b_even,
  output logic [N/2-1:0]   b_odd,
  output logic [N/2-1:0]   b_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int unsigned H     = N / 2;
  localparam int unsigned BEATS = (N + W - 1) / W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, OUT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   beat_cnt, cnt_n;
  logic [N-1:0]    a_reg, b_reg;
  logic [N-1:0]    a_fill, b_fill;
  logic [H-1:0]    ae_n, ao_n, be_n, bo_n;
  logic            accept, last_beat;
  logic            err_n, valid_n, ready_n;
  logic            load_a, load_b, load_out, clear_ops;

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));

  // Operand images with the current beat merged in; bits at or above N are dropped.
  always_comb begin
    a_fill = a_reg;
    b_fill = b_reg;
    for (int i = 0; i < int'(N); i++) begin
      if (CW'(i / int'(W)) == beat_cnt) begin
        a_fill[i] = in_data[i % int'(W)];
        b_fill[i] = in_data[i % int'(W)];
      end
    end
  end

  // De-interleave: A is complete in a_reg, B completes with the current beat.
  always_comb begin
    ae_n = '0;
    ao_n = '0;
    be_n = '0;
    bo_n = '0;
    for (int i = 0; i < int'(H); i++) begin
      ae_n[i] = a_reg[2*i];
      ao_n[i] = a_reg[2*i+1];
      be_n[i] = b_fill[2*i];
      bo_n[i] = b_fill[2*i+1];
    end
  end

  // Next-state and control; framing violations discard the partial frame.
  always_comb begin
    state_n   = state;
    cnt_n     = beat_cnt;
    err_n     = 1'b0;
    valid_n   = out_valid;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_out  = 1'b0;
    clear_ops = 1'b0;
    case (state)
      LOAD_A: begin
        if (accept) begin
          if (in_last) begin
            err_n     = 1'b1;
            clear_ops = 1'b1;
            cnt_n     = '0;
          end else begin
            load_a = 1'b1;
            if (last_beat) begin
              cnt_n   = '0;
              state_n = LOAD_B;
            end else begin
              cnt_n = beat_cnt + CW'(1);
            end
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (last_beat == in_last) begin
            if (last_beat) begin
              load_out = 1'b1;
              valid_n  = 1'b1;
              cnt_n    = '0;
              state_n  = OUT;
            end else begin
              load_b = 1'b1;
              cnt_n  = beat_cnt + CW'(1);
            end
          end else begin
            err_n     = 1'b1;
            clear_ops = 1'b1;
            cnt_n     = '0;
            state_n   = LOAD_A;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_n = 1'b0;
          cnt_n   = '0;
          state_n = LOAD_A;
        end
      end
      default: begin
        state_n = LOAD_A;
        cnt_n   = '0;
      end
    endcase
    ready_n = (state_n != OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      beat_cnt  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      a_even    <= '0;
      a_odd     <= '0;
      a_sum     <= '0;
      b_even    <= '0;
      b_odd     <= '0;
      b_sum     <= '0;
    end else begin
      state     <= state_n;
      beat_cnt  <= cnt_n;
      in_ready  <= ready_n;
      out_valid <= valid_n;
      frame_err <= err_n;
      if (clear_ops) begin
        a_reg <= '0;
        b_reg <= '0;
      end else begin
        if (load_a) a_reg <= a_fill;
        if (load_b || load_out) b_reg <= b_fill;
      end
      if (load_out) begin
        a_even <= ae_n;
        a_odd  <= ao_n;
        a_sum  <= ae_n ^ ao_n;
        b_even <= be_n;
        b_odd  <= bo_n;
        b_sum  <= be_n ^ bo_n;
      end
    end
  end

endmodule
